// File: rtl/gcn_pkg.sv
// Shared types and sizing for the GCN aggregation stage.
// The block's parameters live here as localparams so that the row types
// used by the top and the row adder always agree.
package gcn_pkg;

  localparam int unsigned FEATURE_ROWS    = 6;
  localparam int unsigned WEIGHT_COLS     = 3;
  localparam int unsigned DOT_PROD_WIDTH  = 16;
  localparam int unsigned NUM_OF_NODES    = 6;
  localparam int unsigned COO_NUM_OF_COLS = 6;
  localparam int unsigned COO_BW          = $clog2(COO_NUM_OF_COLS);

  // COO node indices are 1-based; 0 marks an unused edge slot.
  localparam int unsigned COO_IDX_BASE = 1;

  typedef enum logic [1:0] {
    IDLE,
    INIT,
    EDGE,
    DONE
  } agg_state_t;

  typedef logic [DOT_PROD_WIDTH-1:0] dp_t;
  typedef dp_t [WEIGHT_COLS-1:0]     row_t;

endpackage

// File: rtl/gcn_row_adder.sv
// Element-wise add of two product-matrix rows.
// Ports: a, b - addend rows; sum - a + b per column.
// Build option: GCN_AGG_SATURATE_EN clamps each column to all-ones on
// overflow; without it the add wraps modulo 2^DOT_PROD_WIDTH.
module gcn_row_adder
  import gcn_pkg::*;
(
  input  logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0] a,
  input  logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0] b,
  output logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0] sum
);

  for (genvar c = 0; c < WEIGHT_COLS; c++) begin : g_col
`ifdef GCN_AGG_SATURATE_EN
    // One extra bit exposes the carry used for clamping.
    logic [DOT_PROD_WIDTH:0] wide;
    assign wide   = {1'b0, a[c]} + {1'b0, b[c]};
    assign sum[c] = wide[DOT_PROD_WIDTH] ? {DOT_PROD_WIDTH{1'b1}}
                                         : wide[DOT_PROD_WIDTH-1:0];
`else
    assign sum[c] = a[c] + b[c];
`endif
  end

endmodule

// File: rtl/gcn_coo_aggregation.sv
// GCN aggregation stage: agg_out = (A + I) * (FM * WM), with A given as a
// COO edge list walked one edge per cycle.
// Ports:
//   clk, reset (async, active-low)
//   start       - pulse: fm_wm_in is valid (also restarts from DONE)
//   fm_wm_in    - FEATURE_ROWS x WEIGHT_COLS product matrix
//   coo_in      - {src, dst} edge, combinational from coo_address
//   coo_address - edge index being read
//   agg_out     - accumulated matrix (registered); final once done=1
//   done        - agg_out holds the final result
// Build option: GCN_AGG_SATURATE_EN selects saturating adds (see
// gcn_row_adder); default is wrapping adds.
module gcn_coo_aggregation
  import gcn_pkg::*;
(
  input  logic                                             clk,
  input  logic                                             reset,
  input  logic                                             start,
  input  logic [FEATURE_ROWS-1:0][WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0] fm_wm_in,
  input  logic [2*COO_BW-1:0]                              coo_in,
  output logic [COO_BW-1:0]                                coo_address,
  output logic [FEATURE_ROWS-1:0][WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0] agg_out,
  output logic                                             done
);

  localparam logic [COO_BW-1:0] LAST_ADDR = COO_BW'(COO_NUM_OF_COLS - 1);

  agg_state_t state_q;
  agg_state_t state_d;

  // Unmodified copy of the product matrix; every add reads from here so
  // the result does not depend on edge order.
  row_t [FEATURE_ROWS-1:0] shadow;

  logic load_en;
  logic edge_en;
  logic done_d;
  logic last_edge;

  logic [COO_BW-1:0] src;
  logic [COO_BW-1:0] dst;
  logic              edge_valid;
  logic [COO_BW-1:0] s_idx;
  logic [COO_BW-1:0] d_idx;
  row_t              sum_src;
  row_t              sum_dst;

  // Edge decode: out-of-range indices turn the edge into a no-op.
  assign src        = coo_in[2*COO_BW-1:COO_BW];
  assign dst        = coo_in[COO_BW-1:0];
  assign edge_valid = (32'(src) >= COO_IDX_BASE) && (32'(src) <= NUM_OF_NODES) &&
                      (32'(dst) >= COO_IDX_BASE) && (32'(dst) <= NUM_OF_NODES);
  assign s_idx      = edge_valid ? src - COO_BW'(COO_IDX_BASE) : '0;
  assign d_idx      = edge_valid ? dst - COO_BW'(COO_IDX_BASE) : '0;
  assign last_edge  = (coo_address == LAST_ADDR);

  // Source row gains the destination's features and vice versa.
  gcn_row_adder u_src_adder (
    .a   (agg_out[s_idx]),
    .b   (shadow[d_idx]),
    .sum (sum_src)
  );

  gcn_row_adder u_dst_adder (
    .a   (agg_out[d_idx]),
    .b   (shadow[s_idx]),
    .sum (sum_dst)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = INIT;
      INIT:    state_d = EDGE;
      EDGE:    if (last_edge) state_d = DONE;
      DONE:    if (start) state_d = INIT;
      default: state_d = IDLE;
    endcase
  end

  // Datapath controls decoded from the current state.
  always_comb begin
    load_en = 1'b0;
    edge_en = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      INIT:    load_en = 1'b1;
      EDGE:    edge_en = 1'b1;
      DONE:    done_d  = !start;
      default: ;
    endcase
  end

  // Matrix capture, per-edge accumulation, address walk and done flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow      <= '0;
      agg_out     <= '0;
      coo_address <= '0;
      done        <= 1'b0;
    end else begin
      done <= done_d;
      if (load_en) begin
        shadow      <= fm_wm_in;
        agg_out     <= fm_wm_in;
        coo_address <= '0;
      end else if (edge_en) begin
        if (edge_valid) begin
          agg_out[s_idx] <= sum_src;
          // A self-loop contributes once, so only the source side is written.
          if (s_idx != d_idx) agg_out[d_idx] <= sum_dst;
        end
        if (!last_edge) coo_address <= coo_address + COO_BW'(1);
      end
    end
  end

endmodule

// File: tb/tb_gcn_coo_aggregation.sv
// Self-checking bench for gcn_coo_aggregation: directed and random edge
// lists compared against a plain-arithmetic model of (A+I)*FM.
module tb_gcn_coo_aggregation;

  localparam int ROWS    = 6;
  localparam int COLS    = 3;
  localparam int NEDGES  = 6;
  localparam int LATENCY = 8;
  localparam int BOUND   = 40;

  logic                    clk;
  logic                    reset;
  logic                    start;
  logic [5:0][2:0][15:0]   fm_wm_in;
  logic [5:0]              coo_in;
  logic [2:0]              coo_address;
  logic [5:0][2:0][15:0]   agg_out;
  logic                    done;

  logic [15:0] fm_m  [6][3];
  logic [2:0]  e_src [8];
  logic [2:0]  e_dst [8];
  int          exp_m [6][3];

  int checks = 0;
  int errors = 0;

  gcn_coo_aggregation dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .fm_wm_in    (fm_wm_in),
    .coo_in      (coo_in),
    .coo_address (coo_address),
    .agg_out     (agg_out),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar r = 0; r < 6; r++) begin : g_r
    for (genvar c = 0; c < 3; c++) begin : g_c
      assign fm_wm_in[r][c] = fm_m[r][c];
    end
  end

  assign coo_in = {e_src[coo_address], e_dst[coo_address]};

  task automatic clear_fm();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        fm_m[3'(r)][2'(c)] = '0;
  endtask

  task automatic clear_edges();
    for (int e = 0; e < 8; e++) begin
      e_src[3'(e)] = '0;
      e_dst[3'(e)] = '0;
    end
  endtask

  task automatic random_fm();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        fm_m[3'(r)][2'(c)] = ($urandom_range(0, 3) == 0) ? 16'(32'hFFF0 + $urandom_range(0, 15))
                                                          : 16'($urandom_range(0, 2000));
  endtask

  // Mostly valid node ids, occasionally 0 or 7 to exercise skipped edges.
  task automatic random_edges();
    clear_edges();
    for (int e = 0; e < NEDGES; e++) begin
      e_src[3'(e)] = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 6));
      e_dst[3'(e)] = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 6));
    end
  endtask

  // Reference: start from FM (identity term), add neighbour rows for every
  // in-range edge, then wrap or clamp the totals.
  task automatic build_expected();
    int         tot [6][3];
    logic [2:0] s;
    logic [2:0] d;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        tot[3'(r)][2'(c)] = int'(fm_m[3'(r)][2'(c)]);
    for (int e = 0; e < NEDGES; e++) begin
      s = e_src[3'(e)];
      d = e_dst[3'(e)];
      if (s >= 3'd1 && s <= 3'd6 && d >= 3'd1 && d <= 3'd6) begin
        s = s - 3'd1;
        d = d - 3'd1;
        for (int c = 0; c < COLS; c++) begin
          if (s == d) begin
            tot[s][2'(c)] += int'(fm_m[s][2'(c)]);
          end else begin
            tot[s][2'(c)] += int'(fm_m[d][2'(c)]);
            tot[d][2'(c)] += int'(fm_m[s][2'(c)]);
          end
        end
      end
    end
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
`ifdef GCN_AGG_SATURATE_EN
        exp_m[3'(r)][2'(c)] = (tot[3'(r)][2'(c)] > 65535) ? 65535 : tot[3'(r)][2'(c)];
`else
        exp_m[3'(r)][2'(c)] = tot[3'(r)][2'(c)] & 32'hFFFF;
`endif
      end
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that sampled start.
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < BOUND) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++;
    if (coo_address !== 3'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", coo_address); end
    checks++;
    if (agg_out !== '0) begin errors++; $display("FAIL reset_agg got %h want 0", agg_out); end
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL idle_done got %b want 0", done); end
  endtask

  // All edges (0,0): result is the product matrix, done after exactly 8 cycles.
  task automatic test_invalid_edges();
    int cyc;
    clear_edges();
    random_fm();
    pulse_start();
    wait_done(cyc);
    checks++;
    if (cyc != LATENCY) begin errors++; $display("FAIL invalid_latency got %0d want %0d", cyc, LATENCY); end
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        checks++;
        if (agg_out[3'(r)][2'(c)] !== fm_m[3'(r)][2'(c)]) begin
          errors++;
          $display("FAIL invalid_agg[%0d][%0d] got %h want %h", r, c, agg_out[3'(r)][2'(c)], fm_m[3'(r)][2'(c)]);
        end
      end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL done_hold got %b want 1", done); end
    checks++;
    if (coo_address !== 3'(NEDGES - 1)) begin errors++; $display("FAIL addr_hold got %0d want %0d", coo_address, NEDGES - 1); end
  endtask

  // Undirected edge, self-loop and overflow examples with spot constants.
  task automatic test_directed();
    int         cyc;
    logic [2:0] spot_r;
    logic [1:0] spot_c;
    logic [15:0] spot_v;
    for (int k = 0; k < 3; k++) begin
      clear_fm();
      clear_edges();
      case (k)
        0: begin
          fm_m[0][0] = 16'd1;  fm_m[0][1] = 16'd2;  fm_m[0][2] = 16'd3;
          fm_m[1][0] = 16'd10; fm_m[1][1] = 16'd20; fm_m[1][2] = 16'd30;
          e_src[0] = 3'd1; e_dst[0] = 3'd2;
          spot_r = 3'd1; spot_c = 2'd2; spot_v = 16'd33;
        end
        1: begin
          fm_m[2][0] = 16'd4; fm_m[2][1] = 16'd5; fm_m[2][2] = 16'd6;
          e_src[0] = 3'd3; e_dst[0] = 3'd3;
          spot_r = 3'd2; spot_c = 2'd0; spot_v = 16'd8;
        end
        default: begin
          fm_m[0][0] = 16'hFFFF; fm_m[0][1] = 16'd1; fm_m[0][2] = 16'd0;
          fm_m[1][0] = 16'd1;    fm_m[1][1] = 16'd1; fm_m[1][2] = 16'd1;
          e_src[0] = 3'd1; e_dst[0] = 3'd2;
          spot_r = 3'd0; spot_c = 2'd0;
`ifdef GCN_AGG_SATURATE_EN
          spot_v = 16'hFFFF;
`else
          spot_v = 16'h0000;
`endif
        end
      endcase
      build_expected();
      pulse_start();
      wait_done(cyc);
      checks++;
      if (cyc != LATENCY) begin errors++; $display("FAIL directed%0d_latency got %0d want %0d", k, cyc, LATENCY); end
      checks++;
      if (agg_out[spot_r][spot_c] !== spot_v) begin
        errors++;
        $display("FAIL directed%0d_spot got %h want %h", k, agg_out[spot_r][spot_c], spot_v);
      end
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) begin
          checks++;
          if (agg_out[3'(r)][2'(c)] !== 16'(exp_m[3'(r)][2'(c)])) begin
            errors++;
            $display("FAIL directed%0d_agg[%0d][%0d] got %h want %h", k, r, c,
                     agg_out[3'(r)][2'(c)], 16'(exp_m[3'(r)][2'(c)]));
          end
        end
    end
  endtask

  task automatic test_random();
    int cyc;
    for (int n = 0; n < 25; n++) begin
      random_fm();
      random_edges();
      build_expected();
      pulse_start();
      wait_done(cyc);
      checks++;
      if (cyc != LATENCY) begin errors++; $display("FAIL random%0d_latency got %0d want %0d", n, cyc, LATENCY); end
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) begin
          checks++;
          if (agg_out[3'(r)][2'(c)] !== 16'(exp_m[3'(r)][2'(c)])) begin
            errors++;
            $display("FAIL random%0d_agg[%0d][%0d] got %h want %h", n, r, c,
                     agg_out[3'(r)][2'(c)], 16'(exp_m[3'(r)][2'(c)]));
          end
        end
    end
  endtask

  // Reset after two edges clears everything at once; a fresh run is correct.
  task automatic test_reset_mid();
    int cyc;
    random_fm();
    random_edges();
    build_expected();
    pulse_start();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (agg_out !== '0) begin errors++; $display("FAIL midreset_agg got %h want 0", agg_out); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL midreset_done got %b want 0", done); end
    checks++;
    if (coo_address !== 3'd0) begin errors++; $display("FAIL midreset_addr got %0d want 0", coo_address); end
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL postreset_done got %b want 0", done); end
    pulse_start();
    wait_done(cyc);
    checks++;
    if (cyc != LATENCY) begin errors++; $display("FAIL postreset_latency got %0d want %0d", cyc, LATENCY); end
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        checks++;
        if (agg_out[3'(r)][2'(c)] !== 16'(exp_m[3'(r)][2'(c)])) begin
          errors++;
          $display("FAIL postreset_agg[%0d][%0d] got %h want %h", r, c,
                   agg_out[3'(r)][2'(c)], 16'(exp_m[3'(r)][2'(c)]));
        end
      end
  endtask

  // start during EDGE is ignored; start in DONE drops done and recomputes.
  task automatic test_back_to_back();
    int cyc;
    random_fm();
    random_edges();
    build_expected();
    pulse_start();
    repeat (2) @(posedge clk);
    #1;
    pulse_start();
    wait_done(cyc);
    checks++;
    if (cyc + 3 != LATENCY) begin errors++; $display("FAIL ignore_start_latency got %0d want %0d", cyc + 3, LATENCY); end
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        checks++;
        if (agg_out[3'(r)][2'(c)] !== 16'(exp_m[3'(r)][2'(c)])) begin
          errors++;
          $display("FAIL ignore_start_agg[%0d][%0d] got %h want %h", r, c,
                   agg_out[3'(r)][2'(c)], 16'(exp_m[3'(r)][2'(c)]));
        end
      end
    random_fm();
    random_edges();
    build_expected();
    pulse_start();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL restart_done_drop got %b want 0", done); end
    wait_done(cyc);
    checks++;
    if (cyc != LATENCY) begin errors++; $display("FAIL restart_latency got %0d want %0d", cyc, LATENCY); end
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        checks++;
        if (agg_out[3'(r)][2'(c)] !== 16'(exp_m[3'(r)][2'(c)])) begin
          errors++;
          $display("FAIL restart_agg[%0d][%0d] got %h want %h", r, c,
                   agg_out[3'(r)][2'(c)], 16'(exp_m[3'(r)][2'(c)]));
        end
      end
  endtask

  initial begin
    start = 1'b0;
    reset = 1'b0;
    clear_fm();
    clear_edges();
    test_reset();
    test_invalid_edges();
    test_directed();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
